// File: rtl/udma_i2c_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// udma_i2c_cmd_arbiter_if
//   Command-stream bundle between N_REQ command producers and the I2C control
//   FSM, as seen by the arbiter.
//   Producer side : req_cmd_i / req_last_i / req_valid_i  -> arbiter
//                   req_ready_o                           <- arbiter
//   Sink side     : cmd_o / cmd_valid_o                   -> I2C control
//                   cmd_ready_i                           <- I2C control
//   The _i/_o suffixes are from the arbiter's point of view.
//   Modports: slave = arbiter, master = producers + I2C control (env / bench).
// ---------------------------------------------------------------------------
interface udma_i2c_cmd_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int CMD_WIDTH = 32
);
  logic [N_REQ*CMD_WIDTH-1:0] req_cmd_i;
  logic [N_REQ-1:0]           req_last_i;
  logic [N_REQ-1:0]           req_valid_i;
  logic [N_REQ-1:0]           req_ready_o;
  logic [CMD_WIDTH-1:0]       cmd_o;
  logic                       cmd_valid_o;
  logic                       cmd_ready_i;

  modport slave (
    input  req_cmd_i, req_last_i, req_valid_i, cmd_ready_i,
    output req_ready_o, cmd_o, cmd_valid_o
  );

  modport master (
    output req_cmd_i, req_last_i, req_valid_i, cmd_ready_i,
    input  req_ready_o, cmd_o, cmd_valid_o
  );
endinterface

// File: rtl/udma_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// udma_i2c_cmd_arbiter
//   Round-robin, transaction-granular arbiter that shares one I2C command
//   stream between N_REQ producers. A grant lasts from the first word up to
//   the word flagged last. A watchdog aborts an owner that stops presenting
//   words by injecting ABORT_CMD (an I2C STOP).
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   bus (slave)     producer command/handshake lanes and the sink stream
//   cfg_en_i        enables new grants (never interrupts a transaction)
//   cfg_timeout_i   owner idle-cycle limit, 0 disables the watchdog
//   grant_o         one-hot current owner, 0 when none
//   busy_o          transaction or abort in progress
//   timeout_o       one-cycle pulse when the watchdog fires
//   timeout_id_o    index of the last aborted requester
// ---------------------------------------------------------------------------
module udma_i2c_cmd_arbiter #(
  parameter int                   N_REQ     = 2,
  parameter int                   CMD_WIDTH = 32,
  parameter int                   TIMEOUT_W = 16,
  parameter logic [CMD_WIDTH-1:0] ABORT_CMD = 32'h2000_0000
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  udma_i2c_cmd_arbiter_if.slave bus,
  input  logic                 cfg_en_i,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [2:0]           timeout_id_o
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_ABORT} state_e;

  state_e               state_q, state_d;
  logic [2:0]           gnt_q, gnt_d;
  logic [2:0]           rr_q, rr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           tid_q, tid_d;
  logic                 tout_q, tout_d;

  logic [CMD_WIDTH-1:0] own_cmd;
  logic                 own_vld, own_last;
  logic                 pick_vld;
  logic [2:0]           pick_idx;
  logic [2:0]           gnt_nxt;
  logic [TIMEOUT_W:0]   cnt_inc;

  logic [CMD_WIDTH-1:0] cmd_d;
  logic                 cmd_vld_d;
  logic [N_REQ-1:0]     rdy_d, grant_d;

  // Owner lane mux.
  always_comb begin
    own_cmd  = '0;
    own_vld  = 1'b0;
    own_last = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q == 3'(k)) begin
        own_cmd  = bus.req_cmd_i[k*CMD_WIDTH +: CMD_WIDTH];
        own_vld  = bus.req_valid_i[k];
        own_last = bus.req_last_i[k];
      end
    end
  end

  // First valid requester at or after rr_q, cyclically. The loop walks the
  // offsets from the far end so the smallest offset is the last writer.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req_valid_i[idx]) begin
        pick_vld = 1'b1;
        pick_idx = 3'(idx);
      end
    end
  end

  assign gnt_nxt = (gnt_q == 3'(N_REQ - 1)) ? 3'd0 : gnt_q + 3'd1;
  // One extra bit so the live compare never wraps; the stored count saturates.
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    tid_d     = tid_q;
    tout_d    = 1'b0;
    cmd_d     = '0;
    cmd_vld_d = 1'b0;
    rdy_d     = '0;
    grant_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_en_i && pick_vld) begin
          state_d = S_OWN;
          gnt_d   = pick_idx;
          cnt_d   = '0;
        end
      end

      S_OWN: begin
        cmd_d     = own_cmd;
        cmd_vld_d = own_vld;
        for (int k = 0; k < N_REQ; k++) begin
          grant_d[k] = (gnt_q == 3'(k));
          rdy_d[k]   = (gnt_q == 3'(k)) && bus.cmd_ready_i;
        end
        if (own_vld && bus.cmd_ready_i) begin
          cnt_d = '0;
          if (own_last) begin
            state_d = S_IDLE;
            rr_d    = gnt_nxt;
          end
        end else if (!own_vld) begin
          // Only owner silence counts; a stalled sink holds the count.
          if ((cfg_timeout_i != '0) && (cnt_inc >= {1'b0, cfg_timeout_i})) begin
            state_d = S_ABORT;
            tout_d  = 1'b1;
            tid_d   = gnt_q;
            rr_d    = gnt_nxt;
            cnt_d   = '0;
          end else if (!cnt_inc[TIMEOUT_W]) begin
            cnt_d = cnt_inc[TIMEOUT_W-1:0];
          end
        end
      end

      S_ABORT: begin
        cmd_d     = ABORT_CMD;
        cmd_vld_d = 1'b1;
        if (bus.cmd_ready_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      tid_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      tid_q   <= tid_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.cmd_o       = cmd_d;
  assign bus.cmd_valid_o = cmd_vld_d;
  assign bus.req_ready_o = rdy_d;
  assign grant_o         = grant_d;
  assign busy_o          = (state_q != S_IDLE);
  assign timeout_o       = tout_q;
  assign timeout_id_o    = tid_q;

endmodule

// File: tb/tb_udma_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udma_i2c_cmd_arbiter
//   Directed bench for the 2-requester arbiter. Inputs change 1ns after the
//   rising edge; outputs are sampled 1ns later, well clear of the edge.
// ---------------------------------------------------------------------------
module tb_udma_i2c_cmd_arbiter;
  localparam int N_REQ = 2;
  localparam int CW    = 32;
  localparam int TW    = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_en;
  logic [TW-1:0] cfg_timeout;
  logic [1:0]    grant;
  logic          busy, tout;
  logic [2:0]    tid;

  int n_cmp = 0;
  int n_err = 0;

  udma_i2c_cmd_arbiter_if #(.N_REQ(N_REQ), .CMD_WIDTH(CW)) bus ();

  udma_i2c_cmd_arbiter #(.N_REQ(N_REQ), .CMD_WIDTH(CW), .TIMEOUT_W(TW)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .bus           (bus),
    .cfg_en_i      (cfg_en),
    .cfg_timeout_i (cfg_timeout),
    .grant_o       (grant),
    .busy_o        (busy),
    .timeout_o     (tout),
    .timeout_id_o  (tid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [CW-1:0] w, input logic l);
    bus.req_valid_i[k]          = v;
    bus.req_cmd_i[k*CW +: CW]   = w;
    bus.req_last_i[k]           = l;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_en = 1'b1; cfg_timeout = '0; bus.cmd_ready_i = 1'b1;
    bus.req_valid_i = '0; bus.req_last_i = '0; bus.req_cmd_i = '0;
    tick(); tick();
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got %b want 00", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (bus.cmd_valid_o !== 1'b0 || bus.cmd_o !== 32'h0) begin n_err++;
      $display("FAIL reset_cmd got v=%b %h want 0 0", bus.cmd_valid_o, bus.cmd_o); end
    n_cmp++; if (bus.req_ready_o !== 2'b00 || tout !== 1'b0 || tid !== 3'd0) begin n_err++;
      $display("FAIL reset_misc got rdy=%b to=%b id=%0d want 00 0 0", bus.req_ready_o, tout, tid); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_three_words();
    drive(0, 1'b1, 32'hA000_0001, 1'b0);
    #1;
    n_cmp++; if (grant !== 2'b00 || bus.req_ready_o !== 2'b00) begin n_err++;
      $display("FAIL tw_idle got g=%b rdy=%b want 00 00", grant, bus.req_ready_o); end
    tick();
    n_cmp++; if (grant !== 2'b01 || bus.cmd_o !== 32'hA000_0001 || bus.req_ready_o !== 2'b01) begin n_err++;
      $display("FAIL tw_w1 got g=%b cmd=%h rdy=%b want 01 a0000001 01", grant, bus.cmd_o, bus.req_ready_o); end
    tick();
    drive(0, 1'b1, 32'hA000_0002, 1'b0); #1;
    n_cmp++; if (bus.cmd_o !== 32'hA000_0002 || bus.cmd_valid_o !== 1'b1) begin n_err++;
      $display("FAIL tw_w2 got %h v=%b want a0000002 1", bus.cmd_o, bus.cmd_valid_o); end
    tick();
    drive(0, 1'b1, 32'hA000_0003, 1'b1); #1;
    n_cmp++; if (bus.cmd_o !== 32'hA000_0003 || grant !== 2'b01) begin n_err++;
      $display("FAIL tw_w3 got %h g=%b want a0000003 01", bus.cmd_o, grant); end
    tick();
    drive(0, 1'b0, '0, 1'b0); #1;
    n_cmp++; if (busy !== 1'b0 || grant !== 2'b00) begin n_err++;
      $display("FAIL tw_done got busy=%b g=%b want 0 00", busy, grant); end
  endtask

  task automatic test_two_req();
    rstn = 1'b0; #1; rstn = 1'b1;
    tick();
    drive(0, 1'b1, 32'h1000_0000, 1'b0);
    drive(1, 1'b1, 32'h2100_0000, 1'b0);
    tick();
    n_cmp++; if (grant !== 2'b01 || bus.cmd_o !== 32'h1000_0000 || bus.req_ready_o !== 2'b01) begin n_err++;
      $display("FAIL tr_a0 got g=%b cmd=%h rdy=%b want 01 10000000 01", grant, bus.cmd_o, bus.req_ready_o); end
    tick();
    drive(0, 1'b1, 32'h1000_0001, 1'b1); #1;
    n_cmp++; if (grant !== 2'b01 || bus.cmd_o !== 32'h1000_0001) begin n_err++;
      $display("FAIL tr_a1 got g=%b cmd=%h want 01 10000001", grant, bus.cmd_o); end
    tick();
    drive(0, 1'b0, '0, 1'b0); #1;
    n_cmp++; if (grant !== 2'b00 || busy !== 1'b0) begin n_err++;
      $display("FAIL tr_gap got g=%b busy=%b want 00 0", grant, busy); end
    tick();
    n_cmp++; if (grant !== 2'b10 || bus.cmd_o !== 32'h2100_0000 || bus.req_ready_o !== 2'b10) begin n_err++;
      $display("FAIL tr_b0 got g=%b cmd=%h rdy=%b want 10 21000000 10", grant, bus.cmd_o, bus.req_ready_o); end
    tick();
    drive(1, 1'b1, 32'h2100_0001, 1'b1); #1;
    n_cmp++; if (bus.cmd_o !== 32'h2100_0001) begin n_err++;
      $display("FAIL tr_b1 got %h want 21000001", bus.cmd_o); end
    tick();
    drive(1, 1'b0, '0, 1'b0); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tr_done got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    tick();
    drive(0, 1'b1, 32'h3000_0000, 1'b1);
    drive(1, 1'b1, 32'h3100_0000, 1'b1);
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 0) ? 2'b00 : (((i / 2) % 2 == 1) ? 2'b10 : 2'b01);
      n_cmp++; if (grant !== exp_g) begin n_err++;
        $display("FAIL rr_grant[%0d] got %b want %b", i, grant, exp_g); end
      tick();
    end
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_end got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    cfg_timeout = 16'd5;
    drive(0, 1'b1, 32'h4000_0000, 1'b0);
    drive(1, 1'b1, 32'h4100_0000, 1'b1);
    tick();
    n_cmp++; if (grant !== 2'b01 || bus.cmd_o !== 32'h4000_0000) begin n_err++;
      $display("FAIL to_first got g=%b cmd=%h want 01 40000000", grant, bus.cmd_o); end
    tick();
    drive(0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (tout !== 1'b0 || grant !== 2'b01 || busy !== 1'b1) begin n_err++;
      $display("FAIL to_wait got to=%b g=%b busy=%b want 0 01 1", tout, grant, busy); end
    bus.cmd_ready_i = 1'b0;
    tick();
    n_cmp++; if (tout !== 1'b1 || tid !== 3'd0) begin n_err++;
      $display("FAIL to_pulse got to=%b id=%0d want 1 0", tout, tid); end
    n_cmp++; if (bus.cmd_o !== 32'h2000_0000 || bus.cmd_valid_o !== 1'b1 || grant !== 2'b00 || bus.req_ready_o !== 2'b00) begin n_err++;
      $display("FAIL to_abort got cmd=%h v=%b g=%b rdy=%b want 20000000 1 00 00", bus.cmd_o, bus.cmd_valid_o, grant, bus.req_ready_o); end
    tick();
    n_cmp++; if (tout !== 1'b0 || bus.cmd_o !== 32'h2000_0000) begin n_err++;
      $display("FAIL to_hold got to=%b cmd=%h want 0 20000000", tout, bus.cmd_o); end
    bus.cmd_ready_i = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_idle got busy=%b want 0", busy); end
    tick();
    n_cmp++; if (grant !== 2'b10 || bus.cmd_o !== 32'h4100_0000) begin n_err++;
      $display("FAIL to_next got g=%b cmd=%h want 10 41000000", grant, bus.cmd_o); end
    tick();
    drive(1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_sink_stall();
    int fired;
    fired = 0;
    bus.cmd_ready_i = 1'b0;
    drive(0, 1'b1, 32'h5000_0000, 1'b1);
    tick();
    for (int i = 0; i < 100; i++) begin
      if (tout !== 1'b0 || busy !== 1'b1) fired++;
      tick();
    end
    n_cmp++; if (fired != 0) begin n_err++; $display("FAIL st_notimeout got %0d bad cycles want 0", fired); end
    n_cmp++; if (grant !== 2'b01 || bus.cmd_o !== 32'h5000_0000) begin n_err++;
      $display("FAIL st_hold got g=%b cmd=%h want 01 50000000", grant, bus.cmd_o); end
    bus.cmd_ready_i = 1'b1; #1;
    n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL st_ready got %b want 01", bus.req_ready_o); end
    tick();
    drive(0, 1'b0, '0, 1'b0); #1;
    n_cmp++; if (busy !== 1'b0 || tout !== 1'b0) begin n_err++;
      $display("FAIL st_done got busy=%b to=%b want 0 0", busy, tout); end
    cfg_timeout = '0;
  endtask

  task automatic test_cfg_en_and_rst();
    cfg_en = 1'b0;
    drive(0, 1'b1, 32'h6000_0000, 1'b1);
    drive(1, 1'b1, 32'h6100_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (grant !== 2'b00 || busy !== 1'b0) begin n_err++;
        $display("FAIL en_block[%0d] got g=%b busy=%b want 00 0", i, grant, busy); end
    end
    cfg_en = 1'b1;
    tick();
    n_cmp++; if (grant !== 2'b10 || bus.cmd_o !== 32'h6100_0000) begin n_err++;
      $display("FAIL en_grant got g=%b cmd=%h want 10 61000000", grant, bus.cmd_o); end
    tick();
    drive(1, 1'b1, 32'h6100_0001, 1'b1);
    cfg_en = 1'b0; #1;
    n_cmp++; if (grant !== 2'b10 || bus.cmd_o !== 32'h6100_0001) begin n_err++;
      $display("FAIL en_keep got g=%b cmd=%h want 10 61000001", grant, bus.cmd_o); end
    tick();
    drive(1, 1'b1, 32'h6100_0002, 1'b1);
    tick();
    n_cmp++; if (grant !== 2'b00 || busy !== 1'b0) begin n_err++;
      $display("FAIL en_nonew got g=%b busy=%b want 00 0", grant, busy); end
    cfg_en = 1'b1;
    tick();
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL rst_pre got g=%b want 01", grant); end
    rstn = 1'b0; #1;
    n_cmp++; if (grant !== 2'b00 || busy !== 1'b0 || bus.cmd_valid_o !== 1'b0 || bus.cmd_o !== 32'h0 || bus.req_ready_o !== 2'b00) begin n_err++;
      $display("FAIL rst_mid got g=%b busy=%b v=%b cmd=%h rdy=%b want 00 0 0 0 00",
               grant, busy, bus.cmd_valid_o, bus.cmd_o, bus.req_ready_o); end
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    #3 rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_three_words();
    test_two_req();
    test_round_robin();
    test_timeout();
    test_sink_stall();
    test_cfg_en_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/udma_i2c_cmd_arbiter.md
Name: udma_i2c_cmd_arbiter

Overview:
Shares one I2C command stream (32-bit uDMA command words into the I2C control FSM) between N_REQ independent command producers, e.g. several uDMA command channels or a HW sensor poller. Grants one requester for a whole transaction (first word through the word flagged last), so commands from different requesters never interleave on the bus. A watchdog aborts a stalled owner by injecting a configurable STOP command. Sits in the periph clock domain, between the command dc-fifos and the I2C control FSM.

Parameters:
N_REQ, 2, number of requesters (1..8)
CMD_WIDTH, 32, command word width
TIMEOUT_W, 16, watchdog counter width
ABORT_CMD, 32'h2000_0000, word injected on timeout (I2C STOP opcode in [31:28])

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
req_cmd_i  in  N_REQ*CMD_WIDTH  per-requester command word, requester k at [k*CMD_WIDTH +: CMD_WIDTH]
req_last_i  in  N_REQ  word is the final word of its transaction
req_valid_i  in  N_REQ  per-requester valid
req_ready_o  out  N_REQ  per-requester ready
cmd_o  out  CMD_WIDTH  command to I2C control
cmd_valid_o  out  1  command valid
cmd_ready_i  in  1  I2C control ready
cfg_en_i  in  1  enable new grants
cfg_timeout_i  in  TIMEOUT_W  idle-cycle limit while owned; 0 = watchdog disabled
grant_o  out  N_REQ  one-hot current owner, 0 when none
busy_o  out  1  a transaction or abort is in progress
timeout_o  out  1  one-cycle pulse when the watchdog fires
timeout_id_o  out  3  index of the aborted requester, held until next timeout

Behaviour:
- Reset: state IDLE, grant_o=0, rr pointer=0, counter=0, cmd_valid_o=0, req_ready_o=0, busy_o=0, timeout_o=0, timeout_id_o=0, cmd_o=0.
- States: IDLE, OWN, ABORT.
- IDLE: if cfg_en_i and any req_valid_i, pick the first valid index at or after the rr pointer, cyclically. Register the grant and go to OWN next cycle, so there is 1 cycle arbitration latency. No handshake occurs in IDLE.
- OWN (owner g):
  - cmd_o = req_cmd_i[g], cmd_valid_o = req_valid_i[g], req_ready_o[g] = cmd_ready_i. All other ready bits are 0.
  - This is a combinational passthrough: zero latency and no buffering.
  - On a handshake with req_last_i[g]=1: go to IDLE, rr pointer = g+1 mod N_REQ, grant_o=0.
  - A back-to-back next transaction therefore costs 1 idle cycle.
- Watchdog (OWN only):
  - Counter clears on every handshake and on entry to OWN.
  - Increments each cycle the owner's req_valid_i=0.
  - Holds, without incrementing, while valid=1 and cmd_ready_i=0; a sink stall never triggers an abort.
  - When cfg_timeout_i != 0 and the counter reaches cfg_timeout_i: pulse timeout_o, latch timeout_id_o=g, go to ABORT. The rr pointer advances past g.
- ABORT:
  - cmd_o = ABORT_CMD, cmd_valid_o = 1, all req_ready_o = 0, grant_o = 0.
  - Held until cmd_ready_i, then go to IDLE.
  - Words the aborted requester presents afterwards are treated as a new transaction.
- cfg_en_i=0 does not interrupt OWN or ABORT. It only blocks leaving IDLE.
- cfg_timeout_i is sampled live. Lowering it below the current count fires on the next increment (compare is >=).
- busy_o = (state != IDLE).
- Single-word transaction (last on first word): OWN lasts exactly 1 cycle if the sink is ready.
- N_REQ=1: degenerates to passthrough with 1-cycle grant latency and the watchdog.
- Requester deasserting valid mid-transaction is legal. Grant is kept until last or timeout.
- Reset mid-transaction returns to the reset state immediately. No STOP is injected; the sw reset of the I2C control is responsible for the bus.

Test Plan:
- Req0 sends 3 words (last on word 3), sink always ready -> grant_o=01 one cycle after valid; cmd_o shows words 1,2,3 on consecutive cycles; then IDLE, busy_o=0.
- Req0 and req1 both valid from reset, 2 words each -> req0 served first, then req1, with 1 idle cycle between. No interleaving; req1 words never appear while grant_o=01.
- Req0 and req1 continuously requesting 1-word transactions -> grants alternate 01,10,01,10 (round-robin fairness).
- cfg_timeout_i=5; req0 sends 1 non-last word then drops valid -> timeout_o pulses after 5 idle cycles, timeout_id_o=0, cmd_o=32'h2000_0000 until cmd_ready_i. Then req1 is granted if valid.
- Owner holds valid=1 while cmd_ready_i=0 for 100 cycles with cfg_timeout_i=5 -> no timeout, word accepted when ready rises.
- cfg_en_i=0 with pending requests -> grant_o stays 0. Dropping cfg_en_i mid-transaction -> transaction completes, no new grant. rstn_i pulse mid-OWN -> all outputs at reset values immediately.
